// File: rtl/wb_select_decoder.sv
// Register-file write-back decoder: accepts beats, registers a one-hot write
// enable with its data, and walks consecutive registers for multi-beat bursts.
module wb_select_decoder #(
    parameter int SEL_W     = 4,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 4,
    parameter int MASK_ZERO = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [LEN_W-1:0]        in_len,
    input  logic [DATA_W-1:0]       in_data,
    output logic [(1<<SEL_W)-1:0]   out_en,
    output logic [SEL_W-1:0]        out_sel,
    output logic [DATA_W-1:0]       out_data,
    output logic                    busy,
    output logic                    done
);
    localparam int NREG = 1 << SEL_W;

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [NREG-1:0]     out_en_q, out_en_d;
    logic [SEL_W-1:0]    out_sel_q, out_sel_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                done_q, done_d;

    logic                accept;
    logic [SEL_W-1:0]    beat_sel;
    logic [NREG-1:0]     dec;

    assign in_ready = !hold;
    assign accept   = in_valid && in_ready;

    // The first beat of a request takes its destination from the port; later
    // burst beats follow the internal pointer.
    assign beat_sel = (state_q == IDLE) ? in_sel : ptr_q;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
            if (MASK_ZERO != 0 && gi == 0) begin : g_masked
                assign dec[gi] = 1'b0;
            end else begin : g_live
                assign dec[gi] = (beat_sel == SEL_W'(gi));
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        out_en_d   = '0;
        out_sel_d  = out_sel_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;
        if (accept) begin
            out_en_d   = dec;
            out_sel_d  = beat_sel;
            out_data_d = in_data;
            if (state_q == IDLE) begin
                if (in_len != '0) begin
                    ptr_d   = beat_sel + SEL_W'(1);
                    rem_d   = in_len;
                    state_d = BURST;
                end else begin
                    done_d = 1'b1;
                end
            end else begin
                ptr_d = ptr_q + SEL_W'(1);
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            out_en_q   <= '0;
            out_sel_q  <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            out_en_q   <= out_en_d;
            out_sel_q  <= out_sel_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
        end
    end

    assign out_en   = out_en_q;
    assign out_sel  = out_sel_q;
    assign out_data = out_data_q;
    assign done     = done_q;
    assign busy     = (state_q == BURST);
endmodule

// File: tb/tb_wb_select_decoder.sv
// Scoreboard bench for wb_select_decoder: a plain and a register-0-masked
// instance share stimulus; a behavioural model queues expected outputs.
module tb_wb_select_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_sel = 4'd0;
    logic [3:0]  in_len = 4'd0;
    logic [31:0] in_data = 32'd0;

    logic        rdy0, busy0, done0, rdy1, busy1, done1;
    logic [15:0] en0, en1;
    logic [3:0]  sel0, sel1;
    logic [31:0] data0, data1;

    wb_select_decoder #(.SEL_W(4), .DATA_W(32), .LEN_W(4), .MASK_ZERO(0)) u_dut (
        .clk(clk), .rst(rst), .hold(hold), .in_valid(in_valid), .in_ready(rdy0),
        .in_sel(in_sel), .in_len(in_len), .in_data(in_data),
        .out_en(en0), .out_sel(sel0), .out_data(data0), .busy(busy0), .done(done0));

    wb_select_decoder #(.SEL_W(4), .DATA_W(32), .LEN_W(4), .MASK_ZERO(1)) u_dut_mz (
        .clk(clk), .rst(rst), .hold(hold), .in_valid(in_valid), .in_ready(rdy1),
        .in_sel(in_sel), .in_len(in_len), .in_data(in_data),
        .out_en(en1), .out_sel(sel1), .out_data(data1), .busy(busy1), .done(done1));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] en;
        logic [15:0] en_mz;
        logic [3:0]  sel;
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic        mz_same;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state
    logic        m_burst = 1'b0;
    logic [3:0]  m_ptr = 4'd0;
    int          m_rem = 0;
    logic [3:0]  m_sel = 4'd0;
    logic [31:0] m_data = 32'd0;

    function automatic string fmt(input rec_t r);
        return $sformatf("en=%h en_mz=%h sel=%h data=%h busy=%b done=%b mz_same=%b",
                         r.en, r.en_mz, r.sel, r.data, r.busy, r.done, r.mz_same);
    endfunction

    task automatic model_reset();
        m_burst = 1'b0;
        m_ptr   = 4'd0;
        m_rem   = 0;
        m_sel   = 4'd0;
        m_data  = 32'd0;
    endtask

    // Drive one cycle, push the model's expectation, record what the DUT shows.
    task automatic cyc(input logic h, input logic v, input logic [3:0] s,
                       input logic [3:0] l, input logic [31:0] d);
        rec_t e, o;
        logic [3:0] bs;
        hold = h; in_valid = v; in_sel = s; in_len = l; in_data = d;
        e = '0;
        if (v && !h) begin
            bs      = m_burst ? m_ptr : s;
            e.en    = 16'd1 << bs;
            e.en_mz = (bs == 4'd0) ? 16'd0 : e.en;
            m_sel   = bs;
            m_data  = d;
            if (!m_burst) begin
                if (l == 4'd0) begin
                    e.done = 1'b1;
                end else begin
                    m_burst = 1'b1;
                    m_ptr   = 4'(s + 4'd1);
                    m_rem   = int'(l);
                end
            end else begin
                m_ptr = 4'(m_ptr + 4'd1);
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    e.done  = 1'b1;
                    m_burst = 1'b0;
                end
            end
        end
        e.sel     = m_sel;
        e.data    = m_data;
        e.busy    = m_burst;
        e.mz_same = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.en      = en0;
        o.en_mz   = en1;
        o.sel     = sel0;
        o.data    = data0;
        o.busy    = busy0;
        o.done    = done0;
        o.mz_same = (sel1 === sel0) && (data1 === data0) && (busy1 === busy0) && (done1 === done0);
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (en0 !== 16'd0 || en1 !== 16'd0) begin
            errors++; $display("FAIL reset_en got %h/%h want 0000", en0, en1);
        end
        checks++;
        if (sel0 !== 4'd0 || data0 !== 32'd0) begin
            errors++; $display("FAIL reset_sel_data got %h/%h want 0/0", sel0, data0);
        end
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++; $display("FAIL reset_busy_done got %b/%b want 0/0", busy0, done0);
        end
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_single();
        rec_t e, o;
        int n = 0;
        cyc(1'b0, 1'b1, 4'd5, 4'd0, 32'hDEADBEEF);
        checks++;
        if (en0 !== 16'h0020 || sel0 !== 4'd5 || data0 !== 32'hDEADBEEF || done0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL single_literal got en=%h sel=%h data=%h done=%b busy=%b want 0020 5 deadbeef 1 0",
                     en0, sel0, data0, done0, busy0);
        end
        cyc(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL single beat%0d got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
    endtask

    task automatic test_sweep();
        rec_t e, o;
        int n = 0;
        int dones = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 4'(i), 4'd0, 32'h1000_0000 + 32'(i));
            if (done0 === 1'b1) dones++;
        end
        cyc(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        checks++;
        if (dones != 16) begin errors++; $display("FAIL sweep_done_count got %0d want 16", dones); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sweep beat%0d got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
    endtask

    task automatic test_burst_wrap();
        rec_t e, o;
        int n = 0;
        logic [15:0] want_en [4];
        want_en = '{16'h4000, 16'h8000, 16'h0001, 16'h0002};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, (i == 0) ? 4'd14 : 4'd7, (i == 0) ? 4'd3 : 4'd9, 32'hA0 + 32'(i));
            checks++;
            if (en0 !== want_en[i]) begin
                errors++; $display("FAIL wrap_en beat%0d got %h want %h", i, en0, want_en[i]);
            end
        end
        cyc(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL wrap beat%0d got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
    endtask

    task automatic test_stall();
        rec_t e, o;
        int n = 0;
        cyc(1'b0, 1'b1, 4'd2, 4'd2, 32'h11);
        cyc(1'b1, 1'b1, 4'd9, 4'd0, 32'h99);
        cyc(1'b1, 1'b1, 4'd9, 4'd0, 32'h99);
        cyc(1'b0, 1'b0, 4'd9, 4'd0, 32'h98);
        cyc(1'b0, 1'b1, 4'd9, 4'd0, 32'h22);
        cyc(1'b0, 1'b1, 4'd9, 4'd0, 32'h33);
        checks++;
        if (en0 !== 16'h0010 || done0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++; $display("FAIL stall_last got en=%h done=%b busy=%b want 0010 1 0", en0, done0, busy0);
        end
        cyc(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL stall beat%0d got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
    endtask

    task automatic test_mask_zero();
        rec_t e, o;
        int n = 0;
        cyc(1'b0, 1'b1, 4'd15, 4'd1, 32'h5A5A_0001);
        cyc(1'b0, 1'b1, 4'd3, 4'd0, 32'h5A5A_0002);
        checks++;
        if (en1 !== 16'h0000 || sel1 !== 4'd0 || done1 !== 1'b1 || en0 !== 16'h0001) begin
            errors++; $display("FAIL mask_zero got en_mz=%h sel=%h done=%b en=%h want 0000 0 1 0001",
                               en1, sel1, done1, en0);
        end
        cyc(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL mask beat%0d got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
    endtask

    task automatic test_hold_idle();
        rec_t e, o;
        int n = 0;
        hold = 1'b1; in_valid = 1'b1;
        #1;
        checks++;
        if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin errors++; $display("FAIL ready_hold got %b want 0", rdy0); end
        cyc(1'b1, 1'b1, 4'd7, 4'd0, 32'hBAD0_0007);
        cyc(1'b1, 1'b1, 4'd8, 4'd3, 32'hBAD0_0008);
        hold = 1'b0;
        #1;
        checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin errors++; $display("FAIL ready_free got %b want 1", rdy0); end
        cyc(1'b0, 1'b1, 4'd7, 4'd0, 32'h0000_0777);
        cyc(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL hold beat%0d got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
    endtask

    task automatic test_max_burst();
        rec_t e, o;
        int n = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, (i == 0) ? 4'd3 : 4'($urandom_range(15)),
                (i == 0) ? 4'd15 : 4'($urandom_range(15)), $urandom);
            if (i % 5 == 2) cyc(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        end
        cyc(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL maxburst beat%0d got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
    endtask

    task automatic test_reset_mid();
        rec_t e, o;
        int n = 0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'd0, 4'd7, 32'hC0 + 32'(i));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL rstmid beat%0d got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (en0 !== 16'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || sel0 !== 4'd0 || data0 !== 32'd0) begin
            errors++; $display("FAIL rstmid_async got en=%h busy=%b done=%b sel=%h data=%h want all zero",
                               en0, busy0, done0, sel0, data0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, 4'd9, 4'd0, 32'h0000_0909);
        checks++;
        if (en0 !== 16'h0200 || done0 !== 1'b1) begin
            errors++; $display("FAIL rstmid_new got en=%h done=%b want 0200 1", en0, done0);
        end
        cyc(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL rstmid_after beat%0d got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_burst_wrap();
        test_stall();
        test_mask_zero();
        test_hold_idle();
        test_max_burst();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_select_decoder.md
Name: wb_select_decoder

Overview:
- Parametrised register-file write-back decoder for the CPU datapath.
- Accepts write-back beats through a valid/ready handshake and decodes the destination select into a registered one-hot write-enable vector.
- Registers the load/result data alongside the enable so both reach the register file together.
- Supports multi-beat burst writes (load-multiple) to consecutive registers, with auto-increment and wrap-around of the select.

Parameters:
- SEL_W, 4, select width; the enable vector is 2^SEL_W bits wide.
- DATA_W, 32, width of the write-back data path.
- LEN_W, 4, width of the burst length field; a burst is in_len+1 beats.
- MASK_ZERO, 0, when 1, register 0 is hardwired: its enable bit is never asserted.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- hold  input  1  pipeline stall; while high, no beat is accepted.
- in_valid  input  1  a beat is offered this cycle.
- in_ready  output  1  the beat is accepted this cycle; equals !hold.
- in_sel  input  SEL_W  destination register of the first beat; sampled only when a request starts.
- in_len  input  LEN_W  extra beats after the first; sampled only when a request starts.
- in_data  input  DATA_W  data for the current beat.
- out_en  output  2^SEL_W  registered one-hot write enable.
- out_sel  output  SEL_W  registered destination index of the current output beat.
- out_data  output  DATA_W  registered data, aligned with out_en.
- busy  output  1  high while a burst is in progress (state BURST).
- done  output  1  one-cycle pulse, aligned with the output of the final beat of a request.

Behaviour:
- Reset values: out_en=0, out_sel=0, out_data=0, busy=0, done=0, state=IDLE, remaining count=0, select pointer=0. Reset is asynchronous; when it is released, the next edge operates normally.
- Accept rule: a beat is accepted on a rising edge where in_valid && in_ready. in_ready is purely combinational: in_ready = !hold.
- Latency: one cycle. A beat accepted at edge k produces out_en/out_sel/out_data valid from edge k until edge k+1.
- Output pulse width: out_en is a single-cycle pulse per accepted beat. With no accepted beat at an edge, out_en goes to 0. out_data and out_sel hold their last values.
- Decode: out_en[i]=1 exactly when i equals the beat's select. All other bits are 0.
- MASK_ZERO=1 and select==0: out_en is all zeros. out_sel, out_data, the beat count and done behave as for any other beat.
- FSM state IDLE:
  - Accepted beat with in_len==0: single write; done=1 with the output; stay in IDLE.
  - Accepted beat with in_len>0: output the first beat; pointer <= in_sel+1 (mod 2^SEL_W); remaining <= in_len; go to BURST; busy=1 from the next cycle.
- FSM state BURST:
  - in_sel and in_len are ignored; each accepted beat uses the pointer as its select, then pointer increments and remaining decrements.
  - On the beat where remaining==1: done=1 with its output; go to IDLE; busy drops at that same edge.
- Wrap-around: the pointer increments modulo 2^SEL_W, so select 2^SEL_W-1 is followed by 0.
- Maximum burst: in_len = 2^LEN_W-1 gives 2^LEN_W beats. This may exceed 2^SEL_W, in which case the select keeps wrapping.
- Stall: hold=1 or in_valid=0 in BURST inserts bubble cycles (out_en=0). Pointer and count are unchanged, and the burst resumes with no beat lost.
- hold has priority: a beat presented while hold=1 is not accepted and produces no output, even in IDLE.
- Reset mid-burst: immediate return to IDLE with all outputs zero. Remaining beats are discarded and no done is issued.
- done and out_en are never asserted without a corresponding accepted beat.

Test Plan:
- Single write (SEL_W=4): in_sel=5, in_len=0, in_data=0xDEADBEEF, one accepted beat -> next cycle out_en=0x0020, out_sel=5, out_data=0xDEADBEEF, done=1, busy=0; following cycle out_en=0.
- Full decode sweep: sel 0..15 back-to-back, in_len=0 -> out_en=1<<sel on each consecutive cycle; done pulses 16 times; no idle gaps.
- Burst with wrap: in_sel=14, in_len=3, data A,B,C,D on four consecutive beats -> out_en sequence 0x4000, 0x8000, 0x0001, 0x0002 with out_data A..D; busy high for cycles 2-4; done only with D.
- Stall mid-burst: in_sel=2, in_len=2, hold=1 for two cycles after the first beat -> out_en 0x0004, 0, 0, 0x0008, 0x0010; beats stay in order and done arrives with the last one.
- MASK_ZERO=1: in_sel=15, in_len=1 -> out_en 0x8000, then 0x0000 with out_sel=0 and done=1.
- Reset mid-burst: in_len=7, rst asserted after the 3rd beat -> out_en, busy and done go to 0 immediately; a new single request at in_sel=9 then yields out_en=0x0200.
